// File: rtl/ysyx_22041412_hazard_unit.sv
// ysyx_22041412 hazard unit: scoreboard of in-flight destinations,
// operand forwarding to ID, and per-stage hold/bubble/flush control.
module ysyx_22041412_hazard_unit #(
    parameter int XLEN   = 64,
    parameter int NSTAGE = 3,
    parameter int NREAD  = 2,
    parameter int CNTW   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [NREAD*5-1:0]      id_rs,
    input  logic [NREAD-1:0]        id_rs_use,
    input  logic [4:0]              id_rd,
    input  logic                    id_rd_we,
    input  logic [NREAD*XLEN-1:0]   rf_rdata,
    input  logic [NSTAGE*XLEN-1:0]  st_data,
    input  logic [NSTAGE-1:0]       st_data_ok,
    input  logic                    ex_busy,
    input  logic                    mem_busy,
    input  logic                    redirect,
    output logic [NREAD*XLEN-1:0]   fwd_data,
    output logic [NSTAGE+1:0]       hold,
    output logic                    bubble_ex,
    output logic                    flush_id,
    output logic [CNTW-1:0]         stall_cnt
);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
    } sb_t;

    sb_t              sb [NSTAGE];
    logic [NREAD-1:0] hz;
    logic             hazard;
    logic             stall_inc;

    // Youngest-producer search per read port; unfinished producer raises hz.
    always_comb begin
        fwd_data = rf_rdata;
        hz       = '0;
        for (int r = 0; r < NREAD; r++) begin
            logic [4:0] rs;
            logic       hit;
            rs  = id_rs[5*r +: 5];
            hit = 1'b0;
            if (rst && id_rs_use[r]) begin
                if (rs == 5'd0) begin
                    fwd_data[r*XLEN +: XLEN] = '0;
                end else begin
                    for (int k = 0; k < NSTAGE; k++) begin
                        if (!hit && sb[k].v && sb[k].we && sb[k].rd == rs) begin
                            hit = 1'b1;
                            if (st_data_ok[k])
                                fwd_data[r*XLEN +: XLEN] = st_data[k*XLEN +: XLEN];
                            else
                                hz[r] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign hazard    = rst & id_valid & (|hz);
    assign stall_inc = hazard & ~redirect & ~mem_busy & ~ex_busy;

    // Hold priority: memory stall, then EX multi-cycle, then data hazard.
    always_comb begin
        hold      = '0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        if (rst) begin
            flush_id = redirect;
            if (mem_busy) begin
                hold = '1;
            end else if (ex_busy) begin
                hold[2:0] = 3'b111;
            end else if (hazard) begin
                bubble_ex = 1'b1;
                if (!redirect)
                    hold[1:0] = 2'b11;
            end
        end
    end

    // Scoreboard shift and saturating data-hazard stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NSTAGE; k++)
                sb[k] <= '0;
            stall_cnt <= '0;
        end else begin
            if (!mem_busy) begin
                for (int k = 1; k < NSTAGE; k++)
                    sb[k] <= (ex_busy && k == 1) ? '0 : sb[k-1];
                if (!ex_busy)
                    sb[0] <= {id_valid & ~flush_id & ~bubble_ex,
                              id_rd, id_rd_we};
            end
            if (stall_inc && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_hazard_unit.sv
// Bench for ysyx_22041412_hazard_unit: directed scenarios plus
// random traffic against a queue-based pipeline model.
module tb_ysyx_22041412_hazard_unit;

    localparam int XLEN = 64;
    localparam int NS   = 3;
    localparam int NR   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              id_valid = 1'b0;
    logic [NR*5-1:0]   id_rs = '0;
    logic [NR-1:0]     id_rs_use = '0;
    logic [4:0]        id_rd = '0;
    logic              id_rd_we = 1'b0;
    logic [NR*XLEN-1:0] rf_rdata = '0;
    logic [NS*XLEN-1:0] st_data = '0;
    logic [NS-1:0]     st_data_ok = '0;
    logic              ex_busy = 1'b0;
    logic              mem_busy = 1'b0;
    logic              redirect = 1'b0;
    logic [NR*XLEN-1:0] fwd_data;
    logic [NS+1:0]     hold;
    logic              bubble_ex;
    logic              flush_id;
    logic [CW-1:0]     stall_cnt;

    ysyx_22041412_hazard_unit #(
        .XLEN(XLEN), .NSTAGE(NS), .NREAD(NR), .CNTW(CW)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_use(id_rs_use), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .rf_rdata(rf_rdata), .st_data(st_data), .st_data_ok(st_data_ok),
        .ex_busy(ex_busy), .mem_busy(mem_busy), .redirect(redirect),
        .fwd_data(fwd_data), .hold(hold), .bubble_ex(bubble_ex),
        .flush_id(flush_id), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rd;
        bit we;
    } ent_t;

    int             ntests = 0;
    int             nfail  = 0;
    ent_t           q[$];
    int             m_cnt;
    logic [XLEN-1:0] e_fwd [NR];
    bit             e_hz [NR];
    bit             e_hazard;
    logic [NS+1:0]  e_hold;
    bit             e_bub;
    bit             e_fl;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        ent_t nul;
        nul = '{v: 1'b0, rd: 0, we: 1'b0};
        q = {};
        for (int k = 0; k < NS; k++) q.push_back(nul);
        m_cnt = 0;
    endfunction

    // Expected combinational outputs from the in-flight list.
    function automatic void model_comb();
        e_hazard = 1'b0;
        for (int r = 0; r < NR; r++) begin
            int rs;
            int hit;
            rs = int'(id_rs[5*r +: 5]);
            e_fwd[r] = rf_rdata[r*XLEN +: XLEN];
            e_hz[r] = 1'b0;
            hit = -1;
            if (id_rs_use[r] && rs == 0) begin
                e_fwd[r] = '0;
            end else if (id_rs_use[r]) begin
                for (int k = NS - 1; k >= 0; k--)
                    if (q[k].v && q[k].we && q[k].rd == rs) hit = k;
                if (hit >= 0) begin
                    if (st_data_ok[hit]) e_fwd[r] = st_data[hit*XLEN +: XLEN];
                    else e_hz[r] = 1'b1;
                end
            end
            if (id_valid && e_hz[r]) e_hazard = 1'b1;
        end
        if (mem_busy) e_hold = '1;
        else if (ex_busy) e_hold = (NS+2)'(7);
        else if (e_hazard && !redirect) e_hold = (NS+2)'(3);
        else e_hold = '0;
        e_bub = !mem_busy && !ex_busy && e_hazard;
        e_fl  = redirect;
    endfunction

    // Expected list movement on a clock edge.
    function automatic void model_edge();
        ent_t nw;
        if (mem_busy) return;
        if (ex_busy) begin
            nw = '{v: 1'b0, rd: 0, we: 1'b0};
            q.insert(1, nw);
        end else begin
            nw.v  = id_valid && !redirect && !e_hazard;
            nw.rd = int'(id_rd);
            nw.we = id_rd_we;
            q.push_front(nw);
            if (e_hazard && !redirect)
                m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        end
        q = q[0:NS-1];
    endfunction

    task automatic cycle();
        #1;
        model_comb();
        chk("hold", 64'(hold), 64'(e_hold));
        chk("bubble_ex", 64'(bubble_ex), 64'(e_bub));
        chk("flush_id", 64'(flush_id), 64'(e_fl));
        for (int r = 0; r < NR; r++)
            if (!e_hz[r]) chk("fwd_data", fwd_data[r*XLEN +: XLEN], e_fwd[r]);
        @(posedge clk);
        model_edge();
        #1;
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int rd, input bit we,
                         input int rs0, input int rs1, input bit [1:0] u);
        id_valid  = v;
        id_rd     = 5'(rd);
        id_rd_we  = we;
        id_rs     = {5'(rs1), 5'(rs0)};
        id_rs_use = u;
    endtask

    initial begin
        model_reset();
        rf_rdata = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        @(negedge clk);
        #1;
        chk("rst_hold", 64'(hold), 64'd0);
        chk("rst_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_fwd0", fwd_data[63:0], rf_rdata[63:0]);
        @(negedge clk);
        rst = 1'b1;

        // ADD x5 enters EX, then ID reads x5 with the result ready.
        drive(1, 5, 1, 0, 0, 2'b00);
        cycle();
        drive(1, 0, 0, 5, 0, 2'b01);
        st_data[63:0] = 64'h1234;
        st_data_ok = 3'b001;
        #1;
        chk("add_fwd", fwd_data[63:0], 64'h1234);
        chk("add_hold", 64'(hold), 64'd0);
        cycle();

        // LD x7 with late data: one-cycle stall, then forward from MEM.
        drive(1, 7, 1, 0, 0, 2'b00);
        st_data_ok = 3'b000;
        cycle();
        drive(1, 9, 1, 0, 7, 2'b10);
        #1;
        chk("ld_hold", 64'(hold), 64'h3);
        chk("ld_bubble", 64'(bubble_ex), 64'd1);
        cycle();
        chk("ld_cnt", 64'(stall_cnt), 64'd1);
        st_data_ok = 3'b010;
        st_data[127:64] = 64'hDEAD;
        #1;
        chk("ld_fwd", fwd_data[127:64], 64'hDEAD);
        chk("ld_release", 64'(hold), 64'd0);
        cycle();

        // Two writers of x3: the younger (stage 0) wins.
        st_data_ok = 3'b000;
        drive(1, 3, 1, 0, 0, 2'b00);
        cycle();
        cycle();
        drive(1, 0, 1, 3, 0, 2'b01);
        st_data_ok = 3'b011;
        st_data[63:0] = 64'hAA;
        st_data[127:64] = 64'hBB;
        #1;
        chk("young_fwd", fwd_data[63:0], 64'hAA);
        cycle();
        // Stage 0 now "writes" x0; reading x0 must still give zero.
        drive(1, 0, 0, 0, 0, 2'b11);
        st_data_ok = 3'b000;
        #1;
        chk("x0_fwd", fwd_data[63:0], 64'd0);
        chk("x0_hold", 64'(hold), 64'd0);
        cycle();

        // EX multi-cycle with a hazard pending.
        drive(1, 7, 1, 0, 0, 2'b00);
        cycle();
        drive(1, 8, 1, 7, 0, 2'b01);
        ex_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("exb_hold", 64'(hold), 64'h7);
            cycle();
        end
        ex_busy = 1'b0;
        cycle();

        // Redirect on the same cycle as a hazard.
        drive(1, 7, 1, 0, 0, 2'b00);
        cycle();
        drive(1, 9, 1, 7, 0, 2'b01);
        redirect = 1'b1;
        #1;
        chk("rdr_flush", 64'(flush_id), 64'd1);
        chk("rdr_hold", 64'(hold), 64'd0);
        chk("rdr_bubble", 64'(bubble_ex), 64'd1);
        cycle();
        redirect = 1'b0;
        drive(1, 0, 0, 9, 0, 2'b01);
        cycle();

        // Memory stall freezes everything, redirect waits it out.
        mem_busy = 1'b1;
        redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("memb_hold", 64'(hold), 64'h1F);
            cycle();
        end
        mem_busy = 1'b0;
        cycle();
        redirect = 1'b0;

        // Sustained hazards drive the counter into saturation.
        st_data_ok = 3'b000;
        for (int i = 0; i < 32; i++) begin
            drive(1, 7, 1, 7, 0, 2'b01);
            cycle();
        end
        chk("sat_cnt", 64'(stall_cnt), 64'(CMAX));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) != 0), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 7), 2'($urandom_range(0, 3)));
            rf_rdata   = {$urandom, $urandom, $urandom, $urandom};
            st_data    = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom};
            st_data_ok = 3'($urandom_range(0, 7));
            mem_busy   = ($urandom_range(0, 7) == 0);
            ex_busy    = ($urandom_range(0, 7) == 0);
            redirect   = ($urandom_range(0, 7) == 0);
            cycle();
        end

        // Mid-run async reset with three valid producers in flight.
        mem_busy = 1'b0;
        ex_busy = 1'b0;
        redirect = 1'b0;
        st_data_ok = 3'b000;
        for (int i = 1; i <= 3; i++) begin
            drive(1, i, 1, 0, 0, 2'b00);
            cycle();
        end
        drive(1, 4, 1, 1, 2, 2'b11);
        mem_busy = 1'b1;
        redirect = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("mrst_hold", 64'(hold), 64'd0);
        chk("mrst_bubble", 64'(bubble_ex), 64'd0);
        chk("mrst_flush", 64'(flush_id), 64'd0);
        chk("mrst_cnt", 64'(stall_cnt), 64'd0);
        chk("mrst_fwd0", fwd_data[63:0], rf_rdata[63:0]);
        chk("mrst_fwd1", fwd_data[127:64], rf_rdata[127:64]);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        mem_busy = 1'b0;
        redirect = 1'b0;
        #1;
        chk("mrst_nohz", 64'(hold), 64'd0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
